// File: rtl/nebula_pkg.sv
// nebula_pkg: shared unit-select, subcode and scheduler-state types for the Nebula issue path
package nebula_pkg;
  typedef enum logic [1:0] {UNIT_ALU = 2'b00, UNIT_MEM = 2'b01, UNIT_FPU = 2'b10, UNIT_ILL = 2'b11} unit_e;
  typedef enum logic [6:0] {
    ALU_ADD = 7'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;
  typedef enum logic [6:0] {
    MEM_LB = 7'd0, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW, MEM_FLW, MEM_FSW
  } mem_op_e;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_HELD = 2'd1, ST_TRAPPED = 2'd2} sched_state_e;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: 64-entry busy vector (idx[5]=FP file) with two clear ports, one set port, bypassed lookups
module reg_scoreboard (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr0_en,
  input  logic [5:0] clr0_idx,
  input  logic       clr1_en,
  input  logic [5:0] clr1_idx,
  input  logic       set_en,
  input  logic [5:0] set_idx,
  input  logic [5:0] rs1_idx,
  input  logic [5:0] rs2_idx,
  input  logic [5:0] rs3_idx,
  input  logic [5:0] rd_idx,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rs3_busy,
  output logic       rd_busy
);
  logic [63:0] busy, clr, set, eff;
  assign clr = ({63'b0, clr0_en} << clr0_idx) | ({63'b0, clr1_en} << clr1_idx);
  // index 0 is integer x0, which is never tracked
  assign set = {63'b0, set_en && set_idx != 6'd0} << set_idx;
  // lookups see this cycle's writebacks already applied
  assign eff = busy & ~clr;
  assign rs1_busy = eff[rs1_idx];
  assign rs2_busy = eff[rs2_idx];
  assign rs3_busy = eff[rs3_idx];
  assign rd_busy = eff[rd_idx];
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) busy <= '0;
    else busy <= eff | set;
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: single-entry hazard-checked issue stage between decoder and ALU/MEM/FPU
module issue_scheduler
  import nebula_pkg::*;
#(
  parameter int BITS = 32,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [1:0]         dec_unit,
  input  logic [6:0]         dec_op,
  input  logic [4:0]         dec_rd,
  input  logic [4:0]         dec_rs1,
  input  logic [4:0]         dec_rs2,
  input  logic [4:0]         dec_rs3,
  input  logic [2:0]         dec_reg_conf,
  input  logic               dec_rd_we,
  input  logic               dec_rd_fp,
  input  logic [2:0]         dec_rs_fp,
  input  logic [BITS-1:0]    dec_immed,
  output logic               alu_valid,
  input  logic               alu_ready,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic               fpu_valid,
  input  logic               fpu_ready,
  output logic [6:0]         iss_op,
  output logic [4:0]         iss_rd,
  output logic [4:0]         iss_rs1,
  output logic [4:0]         iss_rs2,
  output logic [4:0]         iss_rs3,
  output logic [BITS-1:0]    iss_immed,
  input  logic               wbi_valid,
  input  logic [4:0]         wbi_rd,
  input  logic               wbf_valid,
  input  logic [4:0]         wbf_rd,
  input  logic               flush,
  output logic               trap,
  output logic [STALL_W-1:0] stall_cycles
);
  sched_state_e state;
  logic [1:0] h_unit;
  logic [2:0] h_conf, h_rs_fp;
  logic h_rd_we, h_rd_fp, b1, b2, b3, bd, held, go, issue_fire, accept;
  reg_scoreboard u_sb (
    .clk(clk), .n_rst(n_rst),
    .clr0_en(wbi_valid), .clr0_idx({1'b0, wbi_rd}),
    .clr1_en(wbf_valid), .clr1_idx({1'b1, wbf_rd}),
    .set_en(issue_fire & h_rd_we), .set_idx({h_rd_fp, iss_rd}),
    .rs1_idx({h_rs_fp[0], iss_rs1}), .rs2_idx({h_rs_fp[1], iss_rs2}),
    .rs3_idx({h_rs_fp[2], iss_rs3}), .rd_idx({h_rd_fp, iss_rd}),
    .rs1_busy(b1), .rs2_busy(b2), .rs3_busy(b3), .rd_busy(bd)
  );
  assign held = state == ST_HELD;
  assign go = held & ~flush & ~((h_conf[0] & b1) | (h_conf[1] & b2) | (h_conf[2] & b3) | (h_rd_we & bd));
  assign alu_valid = go & (h_unit == UNIT_ALU);
  assign mem_valid = go & (h_unit == UNIT_MEM);
  assign fpu_valid = go & (h_unit == UNIT_FPU);
  assign issue_fire = (alu_valid & alu_ready) | (mem_valid & mem_ready) | (fpu_valid & fpu_ready);
  assign dec_ready = (state == ST_EMPTY) | issue_fire;
  // flush wins over a same-cycle accept
  assign accept = dec_valid & dec_ready & ~flush;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= ST_EMPTY;
      trap <= 1'b0;
      stall_cycles <= '0;
      {h_unit, h_conf, h_rs_fp, h_rd_we, h_rd_fp} <= '0;
      {iss_op, iss_rd, iss_rs1, iss_rs2, iss_rs3, iss_immed} <= '0;
    end else begin
      state <= flush ? ST_EMPTY : accept ? (dec_unit == UNIT_ILL ? ST_TRAPPED : ST_HELD) : issue_fire ? ST_EMPTY : state;
      trap <= accept & (dec_unit == UNIT_ILL);
      if (held && !issue_fire && !(&stall_cycles)) stall_cycles <= stall_cycles + STALL_W'(1);
      if (accept && dec_unit != UNIT_ILL) begin
        {h_unit, h_conf, h_rs_fp, h_rd_we, h_rd_fp} <= {dec_unit, dec_reg_conf, dec_rs_fp, dec_rd_we, dec_rd_fp};
        {iss_op, iss_rd, iss_rs1, iss_rs2, iss_rs3, iss_immed} <= {dec_op, dec_rd, dec_rs1, dec_rs2, dec_rs3, dec_immed};
      end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed and randomized checks of issue_scheduler against a behavioural model
module tb_issue_scheduler;
  logic clk = 0, n_rst = 0;
  logic dec_valid, dec_ready, dec_rd_we, dec_rd_fp;
  logic [1:0] dec_unit;
  logic [6:0] dec_op, iss_op;
  logic [4:0] dec_rd, dec_rs1, dec_rs2, dec_rs3, iss_rd, iss_rs1, iss_rs2, iss_rs3, wbi_rd, wbf_rd;
  logic [2:0] dec_reg_conf, dec_rs_fp;
  logic [31:0] dec_immed, iss_immed;
  logic alu_valid, alu_ready, mem_valid, mem_ready, fpu_valid, fpu_ready;
  logic wbi_valid, wbf_valid, flush, trap;
  logic [15:0] stall_cycles;
  int checks = 0, failures = 0;
  bit ib[32], fb[32];
  bit m_held, m_trapped, e_trap, m_rd_we, m_rd_fp;
  logic [1:0] m_unit;
  logic [2:0] m_conf, m_rs_fp;
  logic [4:0] m_rd, m_rs1, m_rs2, m_rs3;
  logic [6:0] m_op;
  logic [31:0] m_imm;
  int e_stall;

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk(clk), .n_rst(n_rst), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_unit(dec_unit),
    .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3),
    .dec_reg_conf(dec_reg_conf), .dec_rd_we(dec_rd_we), .dec_rd_fp(dec_rd_fp), .dec_rs_fp(dec_rs_fp),
    .dec_immed(dec_immed), .alu_valid(alu_valid), .alu_ready(alu_ready), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .iss_op(iss_op),
    .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rs3(iss_rs3), .iss_immed(iss_immed),
    .wbi_valid(wbi_valid), .wbi_rd(wbi_rd), .wbf_valid(wbf_valid), .wbf_rd(wbf_rd),
    .flush(flush), .trap(trap), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (ib[i]) begin ib[i] = 0; fb[i] = 0; end
    {m_held, m_trapped, e_trap, m_rd_we, m_rd_fp} = '0;
    {m_unit, m_conf, m_rs_fp, m_rd, m_rs1, m_rs2, m_rs3, m_op, m_imm} = '0;
    e_stall = 0;
  endtask

  function automatic bit bsy(bit fp, logic [4:0] r);
    if (fp) return fb[r] && !(wbf_valid && wbf_rd == r);
    if (r == 0) return 0;
    return ib[r] && !(wbi_valid && wbi_rd == r);
  endfunction

  task automatic idle();
    {dec_valid, dec_unit, dec_op, dec_rd, dec_rs1, dec_rs2, dec_rs3} = '0;
    {dec_reg_conf, dec_rd_we, dec_rd_fp, dec_rs_fp, dec_immed} = '0;
    {wbi_valid, wbi_rd, wbf_valid, wbf_rd, flush} = '0;
  endtask

  task automatic drive(input logic [1:0] u, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] conf, input bit we, rdfp, input logic [2:0] rsfp);
    idle();
    dec_valid = 1; dec_unit = u; dec_op = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_reg_conf = conf; dec_rd_we = we; dec_rd_fp = rdfp; dec_rs_fp = rsfp; dec_immed = {25'd0, op};
  endtask

  // Called just after a falling edge with inputs set; checks, then advances the model across the rising edge.
  task automatic step();
    bit hz, va, vm, vf, fire, rdy, acc;
    #1;
    hz = (m_conf[0] && bsy(m_rs_fp[0], m_rs1)) || (m_conf[1] && bsy(m_rs_fp[1], m_rs2)) ||
         (m_conf[2] && bsy(m_rs_fp[2], m_rs3)) || (m_rd_we && bsy(m_rd_fp, m_rd));
    va = m_held && !flush && !hz && m_unit == 2'd0;
    vm = m_held && !flush && !hz && m_unit == 2'd1;
    vf = m_held && !flush && !hz && m_unit == 2'd2;
    fire = (va && alu_ready) || (vm && mem_ready) || (vf && fpu_ready);
    rdy = (!m_held && !m_trapped) || fire;
    chk("alu_valid", alu_valid, va);
    chk("mem_valid", mem_valid, vm);
    chk("fpu_valid", fpu_valid, vf);
    chk("dec_ready", dec_ready, rdy);
    chk("trap", trap, e_trap);
    chk("stall_cycles", stall_cycles, e_stall);
    chk("iss_rd", iss_rd, m_rd);
    chk("iss_rs1", iss_rs1, m_rs1);
    chk("iss_op", iss_op, m_op);
    chk("iss_immed", iss_immed, m_imm);
    acc = dec_valid && rdy && !flush;
    @(posedge clk);
    if (wbi_valid) ib[wbi_rd] = 0;
    if (wbf_valid) fb[wbf_rd] = 0;
    if (fire && m_rd_we) begin
      if (m_rd_fp) fb[m_rd] = 1;
      else if (m_rd != 0) ib[m_rd] = 1;
    end
    if (m_held && !fire && e_stall < 65535) e_stall++;
    e_trap = acc && dec_unit == 2'd3;
    if (flush) begin m_held = 0; m_trapped = 0; end
    else if (acc && dec_unit == 2'd3) begin m_held = 0; m_trapped = 1; end
    else if (acc) begin
      m_held = 1;
      {m_unit, m_op, m_rd, m_rs1, m_rs2, m_rs3, m_conf, m_rd_we, m_rd_fp, m_rs_fp, m_imm} =
        {dec_unit, dec_op, dec_rd, dec_rs1, dec_rs2, dec_rs3, dec_reg_conf, dec_rd_we, dec_rd_fp, dec_rs_fp, dec_immed};
    end else if (fire) m_held = 0;
    @(negedge clk);
  endtask

  initial begin
    idle();
    {alu_ready, mem_ready, fpu_ready} = 3'b111;
    model_reset();
    repeat (2) @(negedge clk);
    n_rst = 1;
    #1;
    chk("rst_dec_ready", dec_ready, 1);
    chk("rst_valids", {alu_valid, mem_valid, fpu_valid, trap}, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_iss_immed", iss_immed, 0);
    @(negedge clk);
    // independent back-to-back
    drive(2'd0, 7'd0, 5'd1, 5'd0, 5'd0, 3'b000, 1, 0, 3'b000); step();
    drive(2'd0, 7'd0, 5'd2, 5'd0, 5'd0, 3'b000, 1, 0, 3'b000); step();
    idle(); step();
    // RAW on x5 resolved by a same-cycle writeback
    drive(2'd0, 7'd0, 5'd5, 5'd0, 5'd0, 3'b000, 1, 0, 3'b000); step();
    drive(2'd0, 7'd1, 5'd6, 5'd5, 5'd7, 3'b011, 1, 0, 3'b000); step();
    idle(); step(); step(); step();
    wbi_valid = 1; wbi_rd = 5; step();
    idle(); step();
    chk("raw_stall_total", stall_cycles, 3);
    // x0 is never busy
    drive(2'd0, 7'd0, 5'd0, 5'd1, 5'd0, 3'b000, 1, 0, 3'b000); step();
    drive(2'd0, 7'd0, 5'd9, 5'd0, 5'd0, 3'b001, 1, 0, 3'b000); step();
    idle(); step();
    // FP f3 busy does not block int x3
    drive(2'd2, 7'd3, 5'd3, 5'd0, 5'd0, 3'b000, 1, 1, 3'b000); step();
    drive(2'd1, 7'd9, 5'd0, 5'd3, 5'd3, 3'b011, 0, 0, 3'b010); step();
    idle(); step(); step();
    wbf_valid = 1; wbf_rd = 3; step();
    idle(); step();
    // illegal unit traps until flush
    drive(2'd3, 7'd0, 5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 3'b000); step();
    idle(); step(); step();
    flush = 1; step();
    idle(); step();
    // reset while an instruction waits on x5
    drive(2'd0, 7'd0, 5'd5, 5'd0, 5'd0, 3'b000, 1, 0, 3'b000); step();
    drive(2'd0, 7'd1, 5'd6, 5'd5, 5'd0, 3'b001, 1, 0, 3'b000); step();
    idle(); step();
    n_rst = 0;
    #1;
    chk("midrst_valids", {alu_valid, mem_valid, fpu_valid}, 0);
    chk("midrst_ready", dec_ready, 1);
    model_reset();
    @(negedge clk);
    n_rst = 1;
    drive(2'd0, 7'd2, 5'd5, 5'd5, 5'd0, 3'b001, 1, 0, 3'b000); step();
    idle(); step();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      dec_valid = $urandom_range(0, 3) != 0;
      dec_unit = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      dec_op = 7'($urandom);
      dec_rd = 5'($urandom_range(0, 7));
      dec_rs1 = 5'($urandom_range(0, 7));
      dec_rs2 = 5'($urandom_range(0, 7));
      dec_rs3 = 5'($urandom_range(0, 7));
      dec_reg_conf = 3'($urandom);
      dec_rd_we = 1'($urandom);
      dec_rd_fp = 1'($urandom);
      dec_rs_fp = 3'($urandom);
      dec_immed = $urandom;
      alu_ready = $urandom_range(0, 3) != 0;
      mem_ready = $urandom_range(0, 3) != 0;
      fpu_ready = $urandom_range(0, 3) != 0;
      wbi_valid = $urandom_range(0, 2) == 0;
      wbi_rd = 5'($urandom_range(0, 7));
      wbf_valid = $urandom_range(0, 2) == 0;
      wbf_rd = 5'($urandom_range(0, 7));
      flush = m_trapped ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
